// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder: packs RV32I field bundles into 32-bit words and streams them into instruction memory.
// Build option: define ENC_RANGE_CHECK_EN to reject bundles whose immediate does not fit its format.
module rv32i_inst_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_f3,
    input  logic [6:0]        in_f7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [1:0]        dbg_state_o
);
    // Handshakes: a bundle transfers on in_valid && in_ready at the rising edge,
    // a memory write completes on mem_we && mem_ready at the rising edge; start overrides both.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_e;

    localparam logic [ADDR_W:0]   CAP_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic [1:0]        occ_q, occ_d;
    logic [31:0]       head_q, head_d;
    logic [31:0]       tail_q, tail_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              fmt_ok;
    logic              range_ok;
    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W+1:0] level;

    always_comb begin
        enc_word = '0;
        fmt_ok   = 1'b1;
        case (in_fmt)
            3'd0: enc_word = {in_f7, in_rs2, in_rs1, in_f3, in_rd, in_op};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, in_op};
            3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], in_op};
            3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                              in_imm[4:1], in_imm[11], in_op};
            3'd4: enc_word = {in_imm[31:12], in_rd, in_op};
            3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // A value fits N signed bits when every bit from N-1 upward equals the sign.
    always_comb begin
        range_ok = 1'b1;
        case (in_fmt)
            3'd1, 3'd2: range_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            3'd3:       range_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
            3'd4:       range_ok = ~(|in_imm[11:0]);
            3'd5:       range_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
            default:    range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    // Reserve memory for words already queued so the FIFO can never overcommit capacity.
    assign level    = (ADDR_W+2)'(count_q) + (ADDR_W+2)'(occ_q);
    assign in_ready = (state_q == S_RUN) && (occ_q != 2'd2) && (level < {1'b0, CAP_CNT});
    assign legal    = fmt_ok & range_ok;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign pop      = (occ_q != 2'd0) && mem_ready;

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        head_d  = head_q;
        tail_d  = tail_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        if (start) begin
            state_d = S_RUN;
            occ_d   = 2'd0;
            head_d  = '0;
            tail_d  = '0;
            addr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (accept && !legal) begin
                err_d = 1'b1;
            end
            case ({push, pop})
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_d = enc_word;
                    end else begin
                        head_d = tail_q;
                        tail_d = enc_word;
                    end
                end
                2'b10: begin
                    if (occ_q == 2'd0) head_d = enc_word;
                    else               tail_d = enc_word;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                default: ;
            endcase
            if (pop) begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W+1)'(1);
                if ((state_q == S_RUN) && (count_d == CAP_CNT)) begin
                    state_d = S_FULL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            occ_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign mem_we      = (occ_q != 2'd0);
    assign mem_wdata   = head_q;
    assign mem_addr    = addr_q;
    assign count       = count_q;
    assign busy        = (state_q == S_RUN) && (occ_q != 2'd0);
    assign full        = (state_q == S_FULL);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
- Writer-side counterpart of the core's instruction decoder: accepts RV32I field bundles (format, opcode, register indices, funct fields, immediate) over a valid/ready handshake.
- Packs each bundle into a 32-bit instruction word and writes it sequentially into instruction memory through a stallable write port.
- Used by the program loader and self-test logic to fill instruction memory before or while the single-cycle core runs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first write after start.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: flush, clear counters and error, enter RUN.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  bundle accepted when in_valid && in_ready at the clock edge.
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_op  input  7  opcode, copied to inst[6:0].
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_f3  input  3  funct3.
- in_f7  input  7  funct7 (R only).
- in_imm  input  32  signed immediate, byte offset for B/J, full value for U.
- mem_we  output  1  write request.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  write completes when mem_we && mem_ready at the edge.
- count  output  ADDR_W+1  words written since start.
- busy  output  1  RUN with data in flight, or FIFO non-empty.
- full  output  1  memory capacity reached.
- err  output  1  sticky; set on any rejected bundle.

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, mem_addr=BASE_ADDR, count=0, mem_we=0, mem_wdata=0, in_ready=0, busy=0, full=0, err=0. Reset mid-write aborts the write; nothing is retained.
- States:
  - IDLE -> RUN on start.
  - RUN -> FULL when count reaches 2^ADDR_W.
  - Any state -> RUN on start: FIFO flushed, mem_addr=BASE_ADDR, count=0, err=0. start has priority over a same-cycle accept or write.
- in_ready = (state==RUN) && FIFO not full && (count + FIFO occupancy < 2^ADDR_W).
- Encoding (combinational at accept; the result is written into a 2-entry FIFO at the edge):
  - R: f7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Rejected bundle (illegal fmt, or failed range check): accepted (handshake completes), not written to the FIFO, consumes no address, sets err.
- Latency: a bundle accepted at edge N presents mem_we=1 with its word from cycle N+1. Back-to-back throughput is 1 word/cycle while mem_ready=1.
- mem_we = FIFO non-empty; mem_wdata = FIFO head.
- mem_ready=0: mem_addr and mem_wdata hold stable, mem_we stays high.
- On each completed write: FIFO pops, mem_addr increments (wraps modulo 2^ADDR_W), count increments.
- Simultaneous accept and write completion: push and pop in the same cycle, occupancy unchanged.
- full=1 exactly when state==FULL; in_ready=0 in FULL.
- busy=0 in IDLE and FULL.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- Defined: immediates are range-checked and a failing bundle is rejected.
  - I/S: must fit 12-bit signed.
  - B: 13-bit signed and even.
  - J: 21-bit signed and even.
  - U: imm[11:0] must be 0.
- Undefined: no range check; immediate bits are truncated silently and err is set only for illegal fmt.

Test Plan:
- After start, fmt=I, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> mem_we at next cycle, mem_addr=0, mem_wdata=0x00500093, count=1.
- Stream back-to-back, mem_ready=1:
  - R add x3,x1,x2 (op=0x33) -> 0x002081B3.
  - S sw x2,8(x1) (op=0x23, f3=2) -> 0x0020A423.
  - B beq x1,x2,-4 (op=0x63) -> 0xFE208EE3.
  - J jal x1,8 (op=0x6F) -> 0x008000EF.
  - U lui x5,0x12345000 (op=0x37) -> 0x123452B7.
  - Expected: addresses 0..4 consecutive, one word per cycle.
- Hold mem_ready=0 for 5 cycles while sending 3 bundles -> in_ready drops after 2 accepted, mem_addr/mem_wdata stable; release -> remaining words written in order, no loss or duplication.
- With ENC_RANGE_CHECK_EN: fmt=I, imm=4096, then fmt=7 -> both dropped, err=1, count unchanged; next valid bundle is written at the unchanged address. Without the macro, the imm=4096 bundle is written as 0x00000093 (rd=1, op=0x13).
- ADDR_W=2: write 4 words -> full=1, in_ready=0, busy=0; pulse start -> full=0, count=0, mem_addr=0, err=0.
- Assert rst_n=0 while mem_we=1 and mem_ready=0 -> all outputs return to reset values immediately, without waiting for a clock edge.
